// File: rtl/hc4_ram_arbiter.sv
// Two-port sequencer for the HC4 256-nibble RAM: port 0 = core, port 1 = loader.
// Define HC4_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module hc4_ram_arbiter #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_done,
    output logic [3:0] cpu_rdata,
    input  logic       ldr_req,
    input  logic       ldr_we,
    input  logic [7:0] ldr_addr,
    input  logic [3:0] ldr_wdata,
    output logic       ldr_gnt,
    output logic       ldr_done,
    output logic [3:0] ldr_rdata,
    output logic [7:0] address_bus,
    inout  wire  [3:0] data_bus,
    output logic       nRAM_RD,
    output logic       nRAM_WR
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE} state_t;

    state_t     r_state, w_next;
    logic       r_owner, r_we, r_bus_oe;
    logic [7:0] r_addr;
    logic [3:0] r_wdata, r_cpu_rdata, r_ldr_rdata;
    logic [1:0] r_cnt;
    logic       r_nrd, r_nwr, r_cpu_gnt, r_ldr_gnt, r_cpu_done, r_ldr_done;
    logic       w_cpu_elig, w_ldr_elig, w_start, w_pick, w_last;
`ifdef HC4_ARB_ROUND_ROBIN_EN
    logic       r_last_owner;
`endif

    // A port's own done pulse masks its still-high request for that cycle.
    assign w_cpu_elig = cpu_req & ~r_cpu_done;
    assign w_ldr_elig = ldr_req & ~r_ldr_done;
    assign w_last     = (r_cnt == 2'(STROBE_CYCLES - 1));

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_pick  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_elig || w_ldr_elig) begin
                    w_start = 1'b1;
                    w_next  = S_SETUP;
`ifdef HC4_ARB_ROUND_ROBIN_EN
                    w_pick  = (w_cpu_elig && w_ldr_elig) ? ~r_last_owner : ~w_cpu_elig;
`else
                    w_pick  = ~w_cpu_elig;
`endif
                end
            end
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 4'h0;
            r_bus_oe    <= 1'b0;
            r_cnt       <= 2'd0;
            r_nrd       <= 1'b1;
            r_nwr       <= 1'b1;
            r_cpu_gnt   <= 1'b0;
            r_ldr_gnt   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_ldr_done  <= 1'b0;
            r_cpu_rdata <= 4'h0;
            r_ldr_rdata <= 4'h0;
`ifdef HC4_ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_state    <= w_next;
            r_cpu_done <= 1'b0;
            r_ldr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_owner   <= w_pick;
                        r_we      <= w_pick ? ldr_we    : cpu_we;
                        r_addr    <= w_pick ? ldr_addr  : cpu_addr;
                        r_wdata   <= w_pick ? ldr_wdata : cpu_wdata;
                        r_bus_oe  <= w_pick ? ldr_we    : cpu_we;
                        r_cpu_gnt <= ~w_pick;
                        r_ldr_gnt <= w_pick;
`ifdef HC4_ARB_ROUND_ROBIN_EN
                        r_last_owner <= w_pick;
`endif
                    end
                end
                S_SETUP: begin
                    r_nrd <= r_we;
                    r_nwr <= ~r_we;
                    r_cnt <= 2'd0;
                end
                S_STROBE: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_nrd      <= 1'b1;
                        r_nwr      <= 1'b1;
                        r_bus_oe   <= 1'b0;
                        r_cpu_gnt  <= 1'b0;
                        r_ldr_gnt  <= 1'b0;
                        r_cpu_done <= ~r_owner;
                        r_ldr_done <= r_owner;
                        if (!r_we && !r_owner) r_cpu_rdata <= data_bus;
                        if (!r_we &&  r_owner) r_ldr_rdata <= data_bus;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_bus    = r_bus_oe ? r_wdata : 4'bz;
    assign address_bus = r_addr;
    assign nRAM_RD     = r_nrd;
    assign nRAM_WR     = r_nwr;
    assign cpu_gnt     = r_cpu_gnt;
    assign ldr_gnt     = r_ldr_gnt;
    assign cpu_done    = r_cpu_done;
    assign ldr_done    = r_ldr_done;
    assign cpu_rdata   = r_cpu_rdata;
    assign ldr_rdata   = r_ldr_rdata;

endmodule

// File: tb/tb_hc4_ram_arbiter.sv
// Bench for hc4_ram_arbiter: directed protocol steps plus random two-port traffic against a RAM scoreboard.
module tb_hc4_ram_arbiter;

    logic       clk, Reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, ldr_addr;
    logic [3:0] cpu_wdata, ldr_wdata;
    logic       cpu_gnt, cpu_done, ldr_gnt, ldr_done;
    logic [3:0] cpu_rdata, ldr_rdata;
    logic [7:0] address_bus;
    wire  [3:0] data_bus;
    logic       nRAM_RD, nRAM_WR;
    logic [3:0] mem [256];

    // second instance with three strobe cycles, loader port only
    logic       b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we;
    logic [7:0] b_cpu_addr, b_ldr_addr;
    logic [3:0] b_cpu_wdata, b_ldr_wdata;
    logic       b_cpu_gnt, b_cpu_done, b_ldr_gnt, b_ldr_done;
    logic [3:0] b_cpu_rdata, b_ldr_rdata;
    logic [7:0] b_address_bus;
    wire  [3:0] b_data_bus;
    logic       b_nRAM_RD, b_nRAM_WR;
    logic [3:0] mem3 [256];

    int vectors = 0, miscompares = 0;

    hc4_ram_arbiter #(.STROBE_CYCLES(1)) dut (
        .clk(clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .address_bus(address_bus), .data_bus(data_bus), .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR)
    );

    hc4_ram_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), .Reset(Reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_gnt(b_ldr_gnt), .ldr_done(b_ldr_done), .ldr_rdata(b_ldr_rdata),
        .address_bus(b_address_bus), .data_bus(b_data_bus), .nRAM_RD(b_nRAM_RD), .nRAM_WR(b_nRAM_WR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: read drives the bus while nRAM_RD is low, write captures on clock while nRAM_WR is low
    assign data_bus   = nRAM_RD   ? 4'bz : mem[address_bus];
    assign b_data_bus = b_nRAM_RD ? 4'bz : mem3[b_address_bus];

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
        end else if (!nRAM_WR) begin
            mem[address_bus] <= data_bus;
        end
    end

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 4'h0;
        end else if (!b_nRAM_WR) begin
            mem3[b_address_bus] <= b_data_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [7:0] a, input logic [3:0] wd);
        if (p) begin
            ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
    endtask

    // one request on the S=1 instance; hold keeps req high through the edge ending the done cycle
    task automatic access(input bit p, input bit we, input logic [7:0] a, input logic [3:0] wd,
                          input bit hold, output int lat, output int low, output logic [3:0] rd);
        bit seen;
        seen = 1'b0; lat = 0; low = 0; rd = 4'h0;
        drive(p, 1'b1, we, a, wd);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (!nRAM_RD || !nRAM_WR) low++;
            if (p ? ldr_done : cpu_done) begin
                seen = 1'b1;
                lat  = n;
                rd   = p ? ldr_rdata : cpu_rdata;
            end
        end
        chk("done_seen", seen, 1'b1);
        if (hold) @(negedge clk);
        drive(p, 1'b0, 1'b0, 8'h00, 4'h0);
        @(negedge clk);
    endtask

    task automatic b_access(input bit we, input logic [7:0] a, input logic [3:0] wd,
                            output int lat, output int low, output logic [3:0] rd);
        bit seen;
        seen = 1'b0; lat = 0; low = 0; rd = 4'h0;
        b_ldr_we = we; b_ldr_addr = a; b_ldr_wdata = wd; b_ldr_req = 1'b1;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (!b_nRAM_RD || !b_nRAM_WR) low++;
            if (b_ldr_done) begin
                seen = 1'b1;
                lat  = n;
                rd   = b_ldr_rdata;
            end
        end
        chk("s3_done_seen", seen, 1'b1);
        b_ldr_req = 1'b0;
        @(negedge clk);
    endtask

    bit         busy [2], granted [2], pwe [2];
    logic [7:0] paddr [2];
    logic [3:0] pwd [2];
    int         age [2];
    logic [3:0] ref_mem [256];
    logic       prev_low;
    logic [7:0] prev_addr;

    initial begin
        int         lat, low, quiet;
        logic [3:0] rd;
        int         order [$];
        bit         g, d, first;
        logic [3:0] prd;

        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 8'h00; b_cpu_wdata = 4'h0;
        b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = 8'h00; b_ldr_wdata = 4'h0;
        repeat (2) @(negedge clk);

        chk("rst_nrd", nRAM_RD, 1'b1);
        chk("rst_nwr", nRAM_WR, 1'b1);
        chk("rst_addr", address_bus, 8'h00);
        chk("rst_oe", dut.r_bus_oe, 1'b0);
        chk("rst_gnt", {cpu_gnt, ldr_gnt}, 2'b00);
        chk("rst_done", {cpu_done, ldr_done}, 2'b00);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 8'h00);
        Reset = 1'b0;
        @(negedge clk);

        // reset in the middle of a write strobe
        drive(1'b0, 1'b1, 1'b1, 8'h77, 4'h3);
        @(negedge clk);
        chk("abort_setup_gnt", cpu_gnt, 1'b1);
        @(negedge clk);
        chk("abort_strobe_nwr", nRAM_WR, 1'b0);
        Reset = 1'b1;
        #1;
        chk("abort_nwr", nRAM_WR, 1'b1);
        chk("abort_oe", dut.r_bus_oe, 1'b0);
        chk("abort_gnt", cpu_gnt, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        @(negedge clk);
        chk("abort_no_done", cpu_done, 1'b0);
        Reset = 1'b0;
        @(negedge clk);

        // write then read back one nibble
        access(1'b0, 1'b1, 8'h3C, 4'hA, 1'b0, lat, low, rd);
        chk("wr_latency", lat, 3);
        chk("wr_strobe_len", low, 1);
        chk("wr_ram", mem[8'h3C], 4'hA);
        access(1'b0, 1'b0, 8'h3C, 4'h0, 1'b0, lat, low, rd);
        chk("rd_latency", lat, 3);
        chk("rd_strobe_len", low, 1);
        chk("rd_data", rd, 4'hA);

        // request held through the done cycle gives exactly one access
        access(1'b0, 1'b1, 8'h12, 4'h5, 1'b1, lat, low, rd);
        chk("hold_latency", lat, 3);
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (!nRAM_RD || !nRAM_WR || cpu_gnt) quiet++;
        end
        chk("hold_no_dup", quiet, 0);
        chk("hold_ram", mem[8'h12], 4'h5);

        // both ports requesting continuously; last grant so far went to the core
        drive(1'b0, 1'b1, 1'b0, 8'h10, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h20, 4'h0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (cpu_done) order.push_back(0);
            if (ldr_done) order.push_back(1);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
`ifdef HC4_ARB_ROUND_ROBIN_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        chk("contend_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("contend_order", (i < order.size()) ? order[i] : 2, {31'd0, first ^ i[0]});
        repeat (2) @(negedge clk);

        // three-cycle strobe instance, loader at the top address
        b_access(1'b1, 8'hFF, 4'h5, lat, low, rd);
        chk("s3_wr_latency", lat, 5);
        chk("s3_wr_strobe_len", low, 3);
        b_access(1'b0, 8'hFF, 4'h0, lat, low, rd);
        chk("s3_rd_latency", lat, 5);
        chk("s3_rd_strobe_len", low, 3);
        chk("s3_rd_data", rd, 4'h5);

        // random traffic from both ports against the scoreboard
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
        for (int p = 0; p < 2; p++) begin
            busy[p] = 1'b0; granted[p] = 1'b0; age[p] = 0;
        end
        prev_low = 1'b0;
        prev_addr = 8'h00;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            chk("both_strobes_low", !nRAM_RD && !nRAM_WR, 1'b0);
            chk("bus_driven_on_read", dut.r_bus_oe && !nRAM_RD, 1'b0);
            chk("strobe_without_gnt", (!nRAM_RD || !nRAM_WR) && !cpu_gnt && !ldr_gnt, 1'b0);
            chk("dual_gnt", cpu_gnt && ldr_gnt, 1'b0);
            if (prev_low && (!nRAM_RD || !nRAM_WR)) chk("addr_stable", address_bus, prev_addr);
            prev_low  = !nRAM_RD || !nRAM_WR;
            prev_addr = address_bus;
            for (int p = 0; p < 2; p++) begin
                g   = p[0] ? ldr_gnt   : cpu_gnt;
                d   = p[0] ? ldr_done  : cpu_done;
                prd = p[0] ? ldr_rdata : cpu_rdata;
                if (busy[p]) begin
                    age[p]++;
                    if (g) begin
                        chk("gnt_addr", address_bus, paddr[p]);
                        if (pwe[p]) chk("gnt_wdata", data_bus, pwd[p]);
                        if (!granted[p]) begin
                            granted[p] = 1'b1;
                            drive(p[0], 1'b1, 1'($urandom), 8'($urandom), 4'($urandom));
                        end
                    end
                    if (d) begin
                        chk("done_after_gnt", granted[p], 1'b1);
                        if (pwe[p]) ref_mem[paddr[p]] = pwd[p];
                        else        chk("rand_rdata", prd, ref_mem[paddr[p]]);
                        busy[p] = 1'b0;
                        drive(p[0], 1'b0, 1'b0, 8'h00, 4'h0);
                    end else if (age[p] > 20) begin
                        chk("done_within_bound", d, 1'b1);
                        busy[p] = 1'b0;
                        drive(p[0], 1'b0, 1'b0, 8'h00, 4'h0);
                    end
                end else begin
                    chk("idle_port_quiet", g || d, 1'b0);
                    if ($urandom_range(0, 2) == 0) begin
                        busy[p]    = 1'b1;
                        granted[p] = 1'b0;
                        age[p]     = 0;
                        pwe[p]     = 1'($urandom);
                        paddr[p]   = 8'($urandom_range(0, 15));
                        pwd[p]     = 4'($urandom);
                        drive(p[0], 1'b1, pwe[p], paddr[p], pwd[p]);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("ram_contents", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
